// File: rtl/logic16_arbiter_pkg.sv
// Shared opcodes, data width and result bundle for the logic16 arbiter.
// Build option: LOGIC16_ARB_XOR_EN enables opcode 3 as XOR.
package logic16_arbiter_pkg;

  localparam int DATA_W = 16;

  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_NOT = 2'd2;
  localparam logic [1:0] OP_XOR = 2'd3;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } result_t;

endpackage

// File: rtl/logic16_arbiter_gates.sv
// Bitwise gate blocks of the 16-bit logic datapath.
// Build option: none (LOGIC16_ARB_XOR_EN is handled in the top).
module And16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_y
);
  assign o_y = i_a & i_b;
endmodule

module Or16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_y
);
  assign o_y = i_a | i_b;
endmodule

module Not16 (
  input  logic [15:0] i_a,
  output logic [15:0] o_y
);
  assign o_y = ~i_a;
endmodule

// File: rtl/logic16_arbiter_rr.sv
// Round-robin picker: first request at or after ptr wins.
// Build option: none (LOGIC16_ARB_XOR_EN is handled in the top).
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  input  logic             i_enable,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_grant_id
);

  // Circular scan from the pointer; the found flag keeps grant one-hot.
  always_comb begin
    logic w_found;
    int   w_idx;
    o_grant    = '0;
    o_grant_id = '0;
    w_found    = 1'b0;
    w_idx      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = (int'(i_ptr) + k) % N_REQ;
      if (i_enable && !w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_id     = ID_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/logic16_arbiter.sv
// Shares one 16-bit logic unit among N_REQ requesters, one result register.
// Build option: LOGIC16_ARB_XOR_EN makes opcode 3 XOR instead of illegal.
module logic16_arbiter
  import logic16_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [2*N_REQ-1:0]    req_op,
  input  logic [16*N_REQ-1:0]   req_a,
  input  logic [16*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  rsp_err,
  output logic [15:0]           ops_done
);

  logic              r_rsp_valid;
  logic [ID_W-1:0]   r_rsp_id;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_err;
  logic [15:0]       r_ops_done;
  logic [ID_W-1:0]   r_rr_ptr;

  logic              w_can_accept;
  logic [N_REQ-1:0]  w_grant;
  logic [ID_W-1:0]   w_gid;
  logic              w_accept;
  logic [ID_W-1:0]   w_next_ptr;
  logic [1:0]        w_op;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_and;
  logic [DATA_W-1:0] w_or;
  logic [DATA_W-1:0] w_not;
  result_t           w_res;

  assign w_can_accept = !r_rsp_valid || rsp_ready;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .i_req      (req_valid),
    .i_ptr      (r_rr_ptr),
    .i_enable   (w_can_accept),
    .o_grant    (w_grant),
    .o_grant_id (w_gid)
  );

  assign w_accept   = |w_grant;
  assign req_ready  = w_grant;
  assign w_next_ptr = (w_gid == ID_W'(N_REQ - 1)) ? '0
                    : w_gid + ID_W'(1);

  assign w_op = req_op[int'(w_gid)*2 +: 2];
  assign w_a  = req_a[int'(w_gid)*DATA_W +: DATA_W];
  assign w_b  = req_b[int'(w_gid)*DATA_W +: DATA_W];

  And16 u_and (.i_a(w_a), .i_b(w_b), .o_y(w_and));
  Or16  u_or  (.i_a(w_a), .i_b(w_b), .o_y(w_or));
  Not16 u_not (.i_a(w_a), .o_y(w_not));

  // Opcode of the granted requester picks the gate output.
  always_comb begin
    w_res = '{data: '0, err: 1'b0};
    unique case (1'b1)
      (w_op == OP_AND): w_res.data = w_and;
      (w_op == OP_OR):  w_res.data = w_or;
      (w_op == OP_NOT): w_res.data = w_not;
      (w_op == OP_XOR): begin
`ifdef LOGIC16_ARB_XOR_EN
        w_res.data = w_a ^ w_b;
`else
        w_res.err  = 1'b1;
`endif
      end
      default: w_res = '{data: '0, err: 1'b0};
    endcase
  end

  // Result register, round-robin pointer and completion counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_ops_done  <= '0;
      r_rr_ptr    <= '0;
    end else begin
      if (w_accept) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= w_gid;
        r_rsp_data  <= w_res.data;
        r_rsp_err   <= w_res.err;
        r_rr_ptr    <= w_next_ptr;
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
      if (r_rsp_valid && rsp_ready) begin
        r_ops_done <= r_ops_done + 16'd1;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign ops_done  = r_ops_done;

endmodule

// File: tb/tb_logic16_arbiter.sv
// Self-checking bench for logic16_arbiter: vector table plus scoreboard.
// Build option: LOGIC16_ARB_XOR_EN changes the opcode 3 expectation.
module tb_logic16_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [7:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [15:0] ops_done;

  int checks = 0;
  int errors = 0;

  logic16_arbiter #(.N_REQ(4), .ID_W(2)) dut (
    .clock     (clk),
    .reset     (rst),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .ops_done  (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] f_exp(input logic [1:0] op,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
    case (op)
      2'd0:    return {1'b0, a & b};
      2'd1:    return {1'b0, a | b};
      2'd2:    return {1'b0, ~a};
`ifdef LOGIC16_ARB_XOR_EN
      default: return {1'b0, a ^ b};
`else
      default: return {1'b1, 16'h0000};
`endif
    endcase
  endfunction

  function automatic int f_grant(input logic [3:0] v, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  // Scoreboard model
  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] data;
    logic        err;
  } rsp_t;

  rsp_t        q[$];
  rsp_t        m_cur;
  rsp_t        m_new;
  bit          m_valid;
  bit          pend;
  int          m_ptr;
  logic [15:0] m_ops;

  always @(negedge clk) begin
    int          g;
    logic [16:0] r;
    logic [3:0]  exp_rdy;
    if (rst) begin
      q.delete();
      m_valid = 1'b0;
      pend    = 1'b0;
      m_ptr   = 0;
      m_ops   = 16'h0;
    end else begin
      chk("mon_rsp_valid", 32'(rsp_valid), 32'(m_valid));
      chk("mon_ops_done", 32'(ops_done), 32'(m_ops));
      if (pend) begin
        pend = 1'b0;
        if (q.size() == 0) chk("mon_queue_empty", 32'd0, 32'd1);
        else m_cur = q.pop_front();
      end
      if (m_valid) begin
        chk("mon_rsp_id", 32'(rsp_id), 32'(m_cur.id));
        chk("mon_rsp_data", 32'(rsp_data), 32'(m_cur.data));
        chk("mon_rsp_err", 32'(rsp_err), 32'(m_cur.err));
      end
      g = (!m_valid || rsp_ready) ? f_grant(req_valid, m_ptr) : -1;
      exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      chk("mon_req_ready", 32'(req_ready), 32'(exp_rdy));
      if (m_valid && rsp_ready) m_ops = m_ops + 16'd1;
      if (g >= 0) begin
        r = f_exp(req_op[2*g +: 2], req_a[16*g +: 16], req_b[16*g +: 16]);
        m_new.id   = 2'(g);
        m_new.data = r[15:0];
        m_new.err  = r[16];
        q.push_back(m_new);
        pend    = 1'b1;
        m_valid = 1'b1;
        m_ptr   = (g + 1) % 4;
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int r, input logic [1:0] op,
                       input logic [15:0] a, input logic [15:0] b);
    req_valid         = 4'b0001 << r;
    req_op[2*r +: 2]  = op;
    req_a[16*r +: 16] = a;
    req_b[16*r +: 16] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    int          r;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t tv[6];

  initial begin
    tv[0] = '{0, 2'd0, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0};
    tv[1] = '{2, 2'd2, 16'h00FF, 16'h1234, 16'hFF00, 1'b0};
    tv[2] = '{1, 2'd1, 16'h0F00, 16'h000F, 16'h0F0F, 1'b0};
`ifdef LOGIC16_ARB_XOR_EN
    tv[3] = '{3, 2'd3, 16'hAAAA, 16'hFFFF, 16'h5555, 1'b0};
    tv[5] = '{0, 2'd3, 16'h1234, 16'h00FF, 16'h12CB, 1'b0};
`else
    tv[3] = '{3, 2'd3, 16'hAAAA, 16'hFFFF, 16'h0000, 1'b1};
    tv[5] = '{0, 2'd3, 16'h1234, 16'h00FF, 16'h0000, 1'b1};
`endif
    tv[4] = '{1, 2'd0, 16'h1234, 16'hFFFF, 16'h1234, 1'b0};

    rst       = 1'b1;
    req_valid = 4'b0;
    req_op    = 8'h0;
    req_a     = 64'h0;
    req_b     = 64'h0;
    rsp_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_ops_done", 32'(ops_done), 32'd0);
    step();
    rst = 1'b0;

    // Single-requester operations from the table
    foreach (tv[i]) begin
      step();
      drive(tv[i].r, tv[i].op, tv[i].a, tv[i].b);
      step();
      req_valid = 4'b0;
      @(negedge clk);
      chk("vec_valid", 32'(rsp_valid), 32'd1);
      chk("vec_data", 32'(rsp_data), 32'(tv[i].exp_d));
      chk("vec_id", 32'(rsp_id), 32'(tv[i].r));
      chk("vec_err", 32'(rsp_err), 32'(tv[i].exp_e));
    end
    step();

    // Round-robin over all four requesters
    do_reset();
    req_op    = 8'b01_00_01_00;
    req_a     = 64'h4444_3333_2222_1111;
    req_b     = 64'h0F0F_F0F0_00FF_FF00;
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rr_order", 32'(req_ready), 32'(4'b0001 << (i % 4)));
      step();
    end
    req_valid = 4'b0;
    step();
    @(negedge clk);
    chk("rr_ops_done", 32'(ops_done), 32'd8);
    step();

    // Backpressure hold, then drain with simultaneous accept
    drive(0, 2'd1, 16'h00F0, 16'h0F00);
    step();
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_ready", 32'(req_ready), 32'd0);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", 32'(rsp_data), 32'h0FF0);
      chk("hold_id", 32'(rsp_id), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("drain_grant", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b0;
    @(negedge clk);
    chk("drain_new_id", 32'(rsp_id), 32'd1);
    chk("drain_ops", 32'(ops_done), 32'd9);
    step();
    step();

    // Reset while the result register is full
    rsp_ready = 1'b0;
    drive(0, 2'd0, 16'hFFFF, 16'h00FF);
    step();
    req_valid = 4'b0;
    step();
    rst = 1'b1;
    #1;
    chk("rstfull_valid", 32'(rsp_valid), 32'd0);
    chk("rstfull_ops", 32'(ops_done), 32'd0);
    step();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    @(negedge clk);
    chk("rstfull_grant", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'b0;
    step();

    // ops_done wrap
    do_reset();
    req_valid = 4'b1111;
    repeat (65535) step();
    req_valid = 4'b0;
    step();
    @(negedge clk);
    chk("wrap_ffff", 32'(ops_done), 32'hFFFF);
    step();
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0;
    step();
    @(negedge clk);
    chk("wrap_zero", 32'(ops_done), 32'h0000);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
